// File: rtl/control_unit_if.sv
// Control-unit bus: instruction/flag inputs from the datapath and the strobes
// the control unit drives back into it.
interface control_unit_if #(
    parameter int OPCODE_W  = 4,
    parameter int ALU_SEL_W = 3
);
    logic                 start;
    logic [OPCODE_W-1:0]  opcode;
    logic                 zero_flag;
    logic                 carry_flag;
    logic                 LoadIR;
    logic                 IncPC;
    logic                 LoadPC;
    logic                 LoadAcc;
    logic [1:0]           SelAcc;
    logic                 LoadReg;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 halted;

    modport master (
        input  start, opcode, zero_flag, carry_flag,
        output LoadIR, IncPC, LoadPC, LoadAcc, SelAcc, LoadReg, alu_sel, halted
    );

    modport slave (
        output start, opcode, zero_flag, carry_flag,
        input  LoadIR, IncPC, LoadPC, LoadAcc, SelAcc, LoadReg, alu_sel, halted
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FETCH -> DECODE -> EXECUTE control FSM for the 8-bit CPU.
// All strobes are decoded combinationally from the current state and opcode.
module control_unit #(
    parameter int                  OPCODE_W    = 4,
    parameter int                  ALU_SEL_W   = 3,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF
) (
    input  logic          clock,
    input  logic          reset,
    control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 load_ir;
    logic                 inc_pc;
    logic                 load_pc;
    logic                 load_acc;
    logic [1:0]           sel_acc;
    logic                 load_reg;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 halted;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Unused encodings 5-7 fall to the default arm: outputs stay 0 and the FSM returns to idle.
    always_comb begin
        next_state = S_IDLE;
        load_ir    = 1'b0;
        inc_pc     = 1'b0;
        load_pc    = 1'b0;
        load_acc   = 1'b0;
        sel_acc    = 2'b00;
        load_reg   = 1'b0;
        alu_sel    = '0;
        halted     = 1'b0;
        case (state)
            S_IDLE:   next_state = bus.start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                load_ir    = 1'b1;
                inc_pc     = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: next_state = (bus.opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
            S_EXEC: begin
                next_state = S_FETCH;
                case (bus.opcode)
                    4'h1: begin load_acc = 1'b1; sel_acc = 2'b01; end
                    4'h2: begin load_acc = 1'b1; alu_sel = ALU_SEL_W'(0); end
                    4'h3: begin load_acc = 1'b1; alu_sel = ALU_SEL_W'(1); end
                    4'h4: begin load_acc = 1'b1; alu_sel = ALU_SEL_W'(2); end
                    4'h5: begin load_acc = 1'b1; alu_sel = ALU_SEL_W'(3); end
                    4'h6: begin load_acc = 1'b1; alu_sel = ALU_SEL_W'(4); end
                    4'h7: begin load_acc = 1'b1; alu_sel = ALU_SEL_W'(5); end
                    4'h8: load_reg = 1'b1;
                    4'h9: begin load_acc = 1'b1; sel_acc = 2'b10; end
                    4'hA: load_pc = 1'b1;
                    4'hB: load_pc = bus.zero_flag;
                    4'hC: load_pc = bus.carry_flag;
                    4'hD: begin load_acc = 1'b1; alu_sel = ALU_SEL_W'(6); end
                    4'hE: begin load_acc = 1'b1; alu_sel = ALU_SEL_W'(7); end
                    default: ;
                endcase
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign bus.LoadIR  = load_ir;
    assign bus.IncPC   = inc_pc;
    assign bus.LoadPC  = load_pc;
    assign bus.LoadAcc = load_acc;
    assign bus.SelAcc  = sel_acc;
    assign bus.LoadReg = load_reg;
    assign bus.alu_sel = alu_sel;
    assign bus.halted  = halted;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes the expected execute-cycle
// strobes per instruction, a free-running monitor pops and compares them.
module tb_control_unit;

    localparam int          WAIT_MAX = 8;
    localparam logic [10:0] FETCH_V  = 11'h600;
    localparam logic [10:0] HALT_V   = 11'h001;

    logic clock = 1'b0;
    logic reset;

    control_unit_if bus ();

    control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    logic [10:0] expq[$];
    int          checks = 0;
    int          passes = 0;
    logic        mon_en = 1'b0;
    logic        seen_fetch = 1'b0;
    logic        parked = 1'b0;
    int          since_fetch = 0;
    int          lat;

    function automatic logic [10:0] obs();
        return {bus.LoadIR, bus.IncPC, bus.LoadPC, bus.LoadAcc, bus.SelAcc,
                bus.LoadReg, bus.alu_sel, bus.halted};
    endfunction

    // Reference: instruction semantics grouped by class rather than by state.
    function automatic logic [10:0] model(input logic [3:0] op, input logic z, input logic c);
        logic       pc_ld, acc_ld, rf_ld;
        logic [1:0] src;
        logic [2:0] alu;
        pc_ld = 1'b0; acc_ld = 1'b0; rf_ld = 1'b0; src = 2'b00; alu = 3'b000;
        if (op == 4'hF) return HALT_V;
        if (op >= 4'h2 && op <= 4'h7) begin acc_ld = 1'b1; alu = 3'(op - 4'h2); end
        if (op == 4'hD || op == 4'hE) begin acc_ld = 1'b1; alu = 3'(op - 4'hD + 4'h6); end
        if (op == 4'h1) begin acc_ld = 1'b1; src = 2'b01; end
        if (op == 4'h9) begin acc_ld = 1'b1; src = 2'b10; end
        if (op == 4'h8) rf_ld = 1'b1;
        pc_ld = (op == 4'hA) || (op == 4'hB && z) || (op == 4'hC && c);
        return {2'b00, pc_ld, acc_ld, src, rf_ld, alu, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic waitFetch(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!bus.LoadIR && cycles < WAIT_MAX);
        if (!bus.LoadIR) checkOutput("fetch_timeout", 32'd0, 32'd1);
    endtask

    // Called on a fetch negedge; noise flags during fetch must not matter.
    task automatic applyStimulus(input logic [3:0] op, input logic z, input logic c);
        bus.opcode     = op;
        bus.zero_flag  = 1'($urandom);
        bus.carry_flag = 1'($urandom);
        bus.start      = 1'($urandom);
        @(negedge clock);
        bus.zero_flag  = z;
        bus.carry_flag = c;
        expq.push_back(model(op, z, c));
    endtask

    initial begin : monitor
        logic [10:0] o;
        logic [10:0] e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                o = obs();
                checkOutput("exclusive",
                            32'(!(bus.LoadPC && (bus.LoadIR || bus.IncPC)) && !(bus.LoadAcc && bus.LoadReg)),
                            32'd1);
                if (bus.LoadIR) begin
                    if (seen_fetch) checkOutput("cadence", since_fetch, 2);
                    checkOutput("fetch", o, FETCH_V);
                    seen_fetch  = 1'b1;
                    since_fetch = 0;
                end else if (!seen_fetch) begin
                    checkOutput("idle", o, 0);
                end else begin
                    since_fetch++;
                    if (parked) begin
                        checkOutput("halt_hold", o, HALT_V);
                    end else if (since_fetch == 1) begin
                        checkOutput("decode", o, 0);
                    end else if (since_fetch == 2) begin
                        if (expq.size() == 0) begin
                            checkOutput("exec_underflow", o, 32'hFFFF_FFFF);
                        end else begin
                            e = expq.pop_front();
                            checkOutput("exec", o, e);
                            if (e == HALT_V) parked = 1'b1;
                        end
                    end else begin
                        checkOutput("stall", o, FETCH_V);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int dops[13] = '{0, 3, 1, 11, 11, 12, 12, 10, 8, 9, 7, 13, 14};
        int dz[13]   = '{0, 0, 0,  1,  0,  1,  1,  0, 0, 0, 0,  0,  0};
        int dc[13]   = '{1, 1, 1,  0,  1,  1,  0,  0, 0, 0, 0,  0,  0};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.opcode = 4'h0;
        bus.zero_flag = 1'b0;
        bus.carry_flag = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_outputs", obs(), 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checkOutput("idle_no_start", obs(), 0);
        end

        // Reset while an ADD is executing
        bus.start = 1'b1;
        waitFetch(lat);
        checkOutput("first_fetch_latency", lat, 1);
        bus.start = 1'b0;
        bus.opcode = 4'h2;
        @(negedge clock);
        checkOutput("decode_quiet", obs(), 0);
        @(negedge clock);
        checkOutput("exec_add", obs(), model(4'h2, 1'b0, 1'b0));
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_exec", obs(), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checkOutput("idle_after_reset", obs(), 0);
        end

        @(posedge clock);
        #1;
        seen_fetch = 1'b0;
        parked = 1'b0;
        since_fetch = 0;
        mon_en = 1'b1;
        @(negedge clock);
        bus.start = 1'b1;
        waitFetch(lat);
        checkOutput("run_first_fetch_latency", lat, 1);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(4'(dops[i]), 1'(dz[i]), 1'(dc[i]));
            waitFetch(lat);
        end
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(4'($urandom_range(14, 0)), 1'($urandom), 1'($urandom));
            waitFetch(lat);
        end

        applyStimulus(4'hF, 1'($urandom), 1'($urandom));
        repeat (11) begin
            @(negedge clock);
            bus.start = ~bus.start;
        end

        @(posedge clock);
        #1;
        mon_en = 1'b0;
        checkOutput("parked_after_halt", 32'(parked), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("halt_reset", obs(), 0);
        checkOutput("scoreboard_drained", expq.size(), 0);
        @(negedge clock);
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checkOutput("idle_after_halt", obs(), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
